// File: rtl/stopwatch_up_pkg.sv
// Shared types and field limits for the count-up stopwatch and its display word.
// Packed time layout: {hr[26:22], min[21:16], sec[15:10], ms[9:0]}, binary fields.
package stopwatch_up_pkg;

    localparam int HR_W   = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;
    localparam int MS_W   = 10;
    localparam int TIME_W = HR_W + MIN_W + SEC_W + MS_W;

    localparam int MS_LAST  = 999;
    localparam int SEC_LAST = 59;
    localparam int MIN_LAST = 59;

    typedef struct packed {
        logic [HR_W-1:0]  hr;
        logic [MIN_W-1:0] min;
        logic [SEC_W-1:0] sec;
        logic [MS_W-1:0]  ms;
    } time_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_SAT   = 2'd3
    } state_t;

    // True when every field sits at its last value, i.e. the next tick would overflow.
    function automatic logic time_is_max(input time_t t, input int unsigned hr_max);
        return (t.hr  == HR_W'(hr_max))    &&
               (t.min == MIN_W'(MIN_LAST)) &&
               (t.sec == SEC_W'(SEC_LAST)) &&
               (t.ms  == MS_W'(MS_LAST));
    endfunction

endpackage

// File: rtl/stopwatch_up_time_field_counter.sv
// One modulo-(LAST+1) time field; increments on inc_en and flags carry when it wraps.
// Chained by carry to build the full hr:min:sec:ms counter.
module time_field_counter
    import stopwatch_up_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int LAST  = 59
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc_en,
    output logic [WIDTH-1:0] value,
    output logic             carry
);

    localparam logic [WIDTH-1:0] LAST_V = WIDTH'(LAST);

    assign carry = inc_en && (value == LAST_V);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (inc_en) begin
            value <= (value == LAST_V) ? '0 : value + WIDTH'(1);
        end
    end

endmodule

// File: rtl/stopwatch_up.sv
// Count-up stopwatch on a 1 ms tick, saturating at HR_MAX:59:59.999.
// Define STOPWATCH_LAP_EN to enable split-time capture on the lap pulse.
module stopwatch_up
    import stopwatch_up_pkg::*;
#(
    parameter int unsigned HR_MAX = 23
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick_ms,
    input  logic              start_stop,
    input  logic              clear,
    input  logic              lap,
    output logic [TIME_W-1:0] out_time,
    output logic [TIME_W-1:0] lap_time,
    output logic              running,
    output logic              overflow
);

    state_t            state;
    logic [HR_W-1:0]   hr_v;
    logic [MIN_W-1:0]  min_v;
    logic [SEC_W-1:0]  sec_v;
    logic [MS_W-1:0]   ms_v;
    logic              ms_inc, ms_carry, sec_carry, min_carry, unused_hr_carry;
    logic              at_max;
    time_t             cur;

    assign cur      = '{hr: hr_v, min: min_v, sec: sec_v, ms: ms_v};
    assign out_time = cur;
    assign at_max   = time_is_max(cur, HR_MAX);

    // Blocking the chain at max is what prevents any wrap back to zero.
    assign ms_inc = tick_ms && (state == ST_RUN) && !at_max;

    time_field_counter #(.WIDTH(MS_W), .LAST(MS_LAST)) u_ms (
        .clk(clk), .reset(reset), .clear(clear), .inc_en(ms_inc),
        .value(ms_v), .carry(ms_carry)
    );

    time_field_counter #(.WIDTH(SEC_W), .LAST(SEC_LAST)) u_sec (
        .clk(clk), .reset(reset), .clear(clear), .inc_en(ms_carry),
        .value(sec_v), .carry(sec_carry)
    );

    time_field_counter #(.WIDTH(MIN_W), .LAST(MIN_LAST)) u_min (
        .clk(clk), .reset(reset), .clear(clear), .inc_en(sec_carry),
        .value(min_v), .carry(min_carry)
    );

    time_field_counter #(.WIDTH(HR_W), .LAST(int'(HR_MAX))) u_hr (
        .clk(clk), .reset(reset), .clear(clear), .inc_en(min_carry),
        .value(hr_v), .carry(unused_hr_carry)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            running  <= 1'b0;
            overflow <= 1'b0;
        end else if (clear) begin
            state    <= ST_IDLE;
            running  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_stop) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // A tick at max saturates even if start_stop arrives in the same cycle.
                    if (tick_ms && at_max) begin
                        state    <= ST_SAT;
                        running  <= 1'b0;
                        overflow <= 1'b1;
                    end else if (start_stop) begin
                        state   <= ST_PAUSE;
                        running <= 1'b0;
                    end
                end
                ST_PAUSE: begin
                    if (start_stop) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                    end
                end
                ST_SAT: begin
                    state <= ST_SAT;
                end
                default: begin
                    state   <= ST_IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic [TIME_W-1:0] lap_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lap_q <= '0;
        end else if (clear) begin
            lap_q <= '0;
        end else if (lap && (state == ST_RUN || state == ST_PAUSE)) begin
            lap_q <= out_time;
        end
    end

    assign lap_time = lap_q;
`else
    logic unused_lap;
    assign unused_lap = lap;
    assign lap_time   = '0;
`endif

endmodule

// File: tb/tb_stopwatch_up.sv
// Scoreboard bench for stopwatch_up: a millisecond-total model predicts every cycle.
// Honours STOPWATCH_LAP_EN to match whichever build of the design is compiled.
module tb_stopwatch_up;

    localparam int HR_MAX    = 23;
    localparam int MAX_TOTAL = (HR_MAX * 3600 + 3599) * 1000 + 999;
`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, tick_ms, start_stop, clear, lap;
    logic [26:0] out_time, lap_time;
    logic        running, overflow;

    stopwatch_up #(.HR_MAX(HR_MAX)) dut (
        .clk(clk), .reset(reset), .tick_ms(tick_ms), .start_stop(start_stop),
        .clear(clear), .lap(lap), .out_time(out_time), .lap_time(lap_time),
        .running(running), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [26:0] t;
        logic [26:0] lp;
        logic        run;
        logic        ovf;
    } obs_t;

    typedef enum {M_IDLE, M_RUN, M_PAUSE, M_SAT} mstate_t;

    mstate_t m_state;
    int      m_total, m_lap;
    bit      m_ovf;
    obs_t    sb_q[$];
    obs_t    obs_q[$];
    obs_t    e, o;
    int      checks = 0;
    int      failures = 0;

    function automatic logic [26:0] to_time(input int total);
        int hr, mn, sc, ms;
        hr = total / 3600000;
        mn = (total / 60000) % 60;
        sc = (total / 1000) % 60;
        ms = total % 1000;
        return {5'(hr), 6'(mn), 6'(sc), 10'(ms)};
    endfunction

    function automatic void model_reset();
        m_state = M_IDLE;
        m_total = 0;
        m_lap   = 0;
        m_ovf   = 1'b0;
    endfunction

    function automatic void model_step(input bit t, input bit s, input bit c, input bit l);
        if (c) begin
            model_reset();
            return;
        end
        if (LAP_EN && l && (m_state == M_RUN || m_state == M_PAUSE)) m_lap = m_total;
        case (m_state)
            M_IDLE:  if (s) m_state = M_RUN;
            M_RUN: begin
                if (t && m_total == MAX_TOTAL) begin
                    m_state = M_SAT;
                    m_ovf   = 1'b1;
                end else begin
                    if (t) m_total = m_total + 1;
                    if (s) m_state = M_PAUSE;
                end
            end
            M_PAUSE: if (s) m_state = M_RUN;
            default: ;
        endcase
    endfunction

    function automatic obs_t model_out();
        return {to_time(m_total), LAP_EN ? to_time(m_lap) : 27'd0,
                m_state == M_RUN, m_ovf};
    endfunction

    function automatic obs_t sample();
        return {out_time, lap_time, running, overflow};
    endfunction

    task automatic cycle(input bit t, input bit s, input bit c, input bit l);
        @(negedge clk);
        tick_ms = t; start_stop = s; clear = c; lap = l;
        model_step(t, s, c, l);
        sb_q.push_back(model_out());
        @(posedge clk);
        #1;
        obs_q.push_back(sample());
        tick_ms = 0; start_stop = 0; clear = 0; lap = 0;
    endtask

    // Loads the counter fields while the stopwatch is paused, skipping long runs.
    task automatic preload(input int hr, input int mn, input int sc, input int ms);
        @(negedge clk);
        force dut.u_hr.value  = 5'(hr);
        force dut.u_min.value = 6'(mn);
        force dut.u_sec.value = 6'(sc);
        force dut.u_ms.value  = 10'(ms);
        @(negedge clk);
        release dut.u_hr.value;
        release dut.u_min.value;
        release dut.u_sec.value;
        release dut.u_ms.value;
        m_total = ((hr * 60 + mn) * 60 + sc) * 1000 + ms;
    endtask

    task automatic test_reset();
        reset = 1; tick_ms = 0; start_stop = 0; clear = 0; lap = 0;
        model_reset();
        #3;
        checks++;
        if (sample() !== obs_t'(0)) begin
            failures++;
            $display("FAIL reset_init: got %h want 0", sample());
        end
        @(negedge clk);
        reset = 0;
        cycle(0, 1, 0, 0);
        for (int i = 0; i < 5123; i++) cycle(1, 0, 0, 0);
        checks++;
        if (out_time !== {5'd0, 6'd0, 6'd5, 10'd123}) begin
            failures++;
            $display("FAIL reset_prerun: got %h want %h", out_time, {5'd0, 6'd0, 6'd5, 10'd123});
        end
        reset = 1;
        model_reset();
        #1;
        checks++;
        if (sample() !== obs_t'(0)) begin
            failures++;
            $display("FAIL reset_async: got %h want 0", sample());
        end
        @(negedge clk);
        reset = 0;
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL reset_seq: got %h want %h", o, e); end
        end
    endtask

    task automatic test_count_1s();
        cycle(0, 0, 1, 0);
        cycle(0, 1, 0, 0);
        for (int i = 0; i < 1000; i++) cycle(1, 0, 0, 0);
        checks++;
        if (out_time !== {5'd0, 6'd0, 6'd1, 10'd0} || running !== 1'b1) begin
            failures++;
            $display("FAIL count_1s: got t=%h run=%b want t=%h run=1", out_time, running,
                     {5'd0, 6'd0, 6'd1, 10'd0});
        end
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL count_seq: got %h want %h", o, e); end
        end
    endtask

    task automatic test_carry();
        cycle(0, 1, 0, 0);
        preload(0, 0, 59, 999);
        cycle(0, 1, 0, 0);
        cycle(1, 0, 0, 0);
        checks++;
        if (out_time !== {5'd0, 6'd1, 6'd0, 10'd0}) begin
            failures++;
            $display("FAIL carry_min: got %h want %h", out_time, {5'd0, 6'd1, 6'd0, 10'd0});
        end
        cycle(0, 1, 0, 0);
        preload(0, 59, 59, 999);
        cycle(0, 1, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        checks++;
        if (out_time !== {5'd1, 6'd0, 6'd0, 10'd1}) begin
            failures++;
            $display("FAIL carry_hr: got %h want %h", out_time, {5'd1, 6'd0, 6'd0, 10'd1});
        end
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL carry_seq: got %h want %h", o, e); end
        end
    endtask

    task automatic test_saturation();
        cycle(0, 1, 0, 0);
        preload(23, 59, 59, 998);
        cycle(0, 1, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        checks++;
        if (out_time !== {5'd23, 6'd59, 6'd59, 10'd999} || overflow !== 1'b1 || running !== 1'b0) begin
            failures++;
            $display("FAIL sat_hold: got t=%h ovf=%b run=%b want t=%h ovf=1 run=0",
                     out_time, overflow, running, {5'd23, 6'd59, 6'd59, 10'd999});
        end
        cycle(1, 0, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 1, 0);
        checks++;
        if (sample() !== obs_t'(0)) begin
            failures++;
            $display("FAIL sat_clear: got %h want 0", sample());
        end
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL sat_seq: got %h want %h", o, e); end
        end
    endtask

    task automatic test_simultaneous();
        cycle(0, 0, 1, 0);
        cycle(0, 1, 0, 0);
        for (int i = 0; i < 10; i++) cycle(1, 0, 0, 0);
        cycle(1, 1, 0, 0);
        checks++;
        if (out_time !== 27'd11 || running !== 1'b0) begin
            failures++;
            $display("FAIL simul_pause: got t=%h run=%b want t=00b run=0", out_time, running);
        end
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        checks++;
        if (out_time !== 27'd13 || running !== 1'b1) begin
            failures++;
            $display("FAIL simul_resume: got t=%h run=%b want t=00d run=1", out_time, running);
        end
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL simul_seq: got %h want %h", o, e); end
        end
    endtask

    task automatic test_lap();
        logic [26:0] want_lap;
        want_lap = LAP_EN ? {5'd0, 6'd0, 6'd2, 10'd500} : 27'd0;
        cycle(0, 0, 1, 0);
        cycle(0, 1, 0, 0);
        for (int i = 0; i < 2500; i++) cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 1);
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0);
        checks++;
        if (lap_time !== want_lap || out_time !== {5'd0, 6'd0, 6'd2, 10'd506}) begin
            failures++;
            $display("FAIL lap_capture: got lap=%h t=%h want lap=%h t=%h", lap_time, out_time,
                     want_lap, {5'd0, 6'd0, 6'd2, 10'd506});
        end
        cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 1, 1);
        cycle(0, 0, 0, 1);
        checks++;
        if (lap_time !== 27'd0) begin
            failures++;
            $display("FAIL lap_clear: got %h want 0", lap_time);
        end
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL lap_seq: got %h want %h", o, e); end
        end
    endtask

    task automatic test_back_to_back();
        cycle(0, 1, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 1, 1, 0);
        checks++;
        if (out_time !== 27'd0 || running !== 1'b0) begin
            failures++;
            $display("FAIL b2b_clear_wins: got t=%h run=%b want t=0 run=0", out_time, running);
        end
        cycle(0, 1, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(1, 0, 0, 0);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL b2b_seq: got %h want %h", o, e); end
        end
    endtask

    initial begin
        test_reset();
        test_count_1s();
        test_carry();
        test_saturation();
        test_simultaneous();
        test_lap();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
